// File: rtl/ttt_board_ctrl_if.sv
// ttt_board_ctrl_if: push-button inputs and cell-colour/status outputs of the tic-tac-toe controller
interface ttt_board_ctrl_if;
    logic       btn_move;
    logic       btn_place;
    logic [2:0] A1_color, A2_color, A3_color;
    logic [2:0] B1_color, B2_color, B3_color;
    logic [2:0] C1_color, C2_color, C3_color;
    logic       turn;
    logic [1:0] winner;
    logic       game_over;
    modport master (
        input  btn_move, btn_place,
        output A1_color, A2_color, A3_color, B1_color, B2_color, B3_color,
               C1_color, C2_color, C3_color, turn, winner, game_over
    );
    modport slave (
        output btn_move, btn_place,
        input  A1_color, A2_color, A3_color, B1_color, B2_color, B3_color,
               C1_color, C2_color, C3_color, turn, winner, game_over
    );
endinterface

// File: rtl/ttt_board_ctrl.sv
// ttt_board_ctrl: tic-tac-toe game-state controller driving the nine cell colours of the grid display
// TTT_WIN_BLINK_EN: when defined, winning cells blink with a BLINK_DIV-cycle half-period
module ttt_board_ctrl #(
    parameter logic [2:0] P1_COLOR     = 3'b100,
    parameter logic [2:0] P2_COLOR     = 3'b001,
    parameter logic [2:0] EMPTY_COLOR  = 3'b111,
    parameter logic [2:0] CURSOR_COLOR = 3'b110
`ifdef TTT_WIN_BLINK_EN
    ,
    parameter int BLINK_DIV = 25_000_000
`endif
) (
    input logic clk,
    input logic rst,
    ttt_board_ctrl_if.master bus
);
    typedef enum logic [1:0] {PLAY, EVAL, WIN, DRAW} state_t;
    // three 4-bit cell indices per line: rows, columns, diagonals
    localparam logic [7:0][11:0] LINES = {
        12'h012, 12'h345, 12'h678, 12'h036, 12'h147, 12'h258, 12'h048, 12'h246
    };
    state_t           state, state_n;
    logic [2:0]       mv_sh, pl_sh;
    logic             move_evt, place_evt;
    logic [8:0][1:0]  board, board_n;
    logic [3:0]       cursor, cursor_n;
    logic             turn, turn_n;
    logic [1:0]       winner, winner_n;
    logic [8:0]       win_mask, mask_n, hmask;
    logic [8:0][2:0]  color_q, color_n;
    logic             hit, full, blink, hide;
    logic [1:0]       own;
`ifdef TTT_WIN_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (state != WIN) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (cnt == CW'(BLINK_DIV - 1)) begin
            cnt   <= '0;
            blink <= ~blink;
        end else
            cnt <= cnt + 1'b1;
`else
    assign blink = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            mv_sh     <= '0;
            pl_sh     <= '0;
            move_evt  <= 1'b0;
            place_evt <= 1'b0;
            state     <= PLAY;
            board     <= '0;
            cursor    <= '0;
            turn      <= 1'b0;
            winner    <= '0;
            win_mask  <= '0;
            color_q   <= {9{EMPTY_COLOR}};
        end else begin
            mv_sh     <= {mv_sh[1:0], bus.btn_move};
            pl_sh     <= {pl_sh[1:0], bus.btn_place};
            move_evt  <= mv_sh[1] & ~mv_sh[2];
            place_evt <= pl_sh[1] & ~pl_sh[2];
            state     <= state_n;
            board     <= board_n;
            cursor    <= cursor_n;
            turn      <= turn_n;
            winner    <= winner_n;
            win_mask  <= mask_n;
            color_q   <= color_n;
        end
    always_comb begin
        state_n  = state;
        board_n  = board;
        cursor_n = cursor;
        turn_n   = turn;
        winner_n = winner;
        mask_n   = win_mask;
        hit      = 1'b0;
        own      = 2'b00;
        hmask    = '0;
        full     = 1'b1;
        for (int l = 0; l < 8; l++)
            if (!hit && board[LINES[l][11:8]] != 2'b00 &&
                board[LINES[l][11:8]] == board[LINES[l][7:4]] &&
                board[LINES[l][11:8]] == board[LINES[l][3:0]]) begin
                hit   = 1'b1;
                own   = board[LINES[l][11:8]];
                hmask = (9'b1 << LINES[l][11:8]) | (9'b1 << LINES[l][7:4]) | (9'b1 << LINES[l][3:0]);
            end
        for (int i = 0; i < 9; i++)
            if (board[i] == 2'b00) full = 1'b0;
        case (state)
            PLAY:
                if (place_evt) begin
                    if (board[cursor] == 2'b00) begin
                        board_n[cursor] = turn ? 2'b10 : 2'b01;
                        state_n         = EVAL;
                    end
                end else if (move_evt)
                    cursor_n = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
            EVAL:
                if (hit) begin
                    state_n  = WIN;
                    winner_n = own;
                    mask_n   = hmask;
                end else if (full) begin
                    state_n  = DRAW;
                    winner_n = 2'b11;
                end else begin
                    state_n = PLAY;
                    turn_n  = ~turn;
                end
            default:
                if (place_evt) begin
                    state_n  = PLAY;
                    board_n  = '0;
                    cursor_n = '0;
                    turn_n   = 1'b0;
                    winner_n = '0;
                    mask_n   = '0;
                end
        endcase
    end
    assign hide = (state == WIN) && blink;
    always_comb begin
        color_n = '0;
        for (int i = 0; i < 9; i++)
            color_n[i] = (hide && win_mask[i]) ? EMPTY_COLOR :
                         board[i] == 2'b01 ? P1_COLOR :
                         board[i] == 2'b10 ? P2_COLOR :
                         (state == PLAY && cursor == 4'(i)) ? CURSOR_COLOR : EMPTY_COLOR;
    end
    assign bus.A1_color  = color_q[0];
    assign bus.A2_color  = color_q[1];
    assign bus.A3_color  = color_q[2];
    assign bus.B1_color  = color_q[3];
    assign bus.B2_color  = color_q[4];
    assign bus.B3_color  = color_q[5];
    assign bus.C1_color  = color_q[6];
    assign bus.C2_color  = color_q[7];
    assign bus.C3_color  = color_q[8];
    assign bus.turn      = turn;
    assign bus.winner    = winner;
    assign bus.game_over = (state == WIN) || (state == DRAW);
endmodule

// File: tb/tb_ttt_board_ctrl.sv
// tb_ttt_board_ctrl: directed self-checking bench for the tic-tac-toe controller
module tb_ttt_board_ctrl;
    localparam logic [2:0] P1 = 3'b100, P2 = 3'b001, EM = 3'b111, CU = 3'b110;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int tests = 0, fails = 0, cur = 0;
    logic [8:0][2:0] col, exp_col;
    always #5 clk = ~clk;
    ttt_board_ctrl_if bus();
`ifdef TTT_WIN_BLINK_EN
    ttt_board_ctrl #(.BLINK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
    ttt_board_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif
    assign col = {bus.C3_color, bus.C2_color, bus.C1_color, bus.B3_color, bus.B2_color,
                  bus.B1_color, bus.A3_color, bus.A2_color, bus.A1_color};

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit m, input bit p);
        bus.btn_move  = m;
        bus.btn_place = p;
        cycles(3);
        bus.btn_move  = 1'b0;
        bus.btn_place = 1'b0;
        cycles(8);
    endtask

    task automatic goto_cell(input int t);
        while (cur != t) begin
            press(1'b1, 1'b0);
            cur = (cur + 1) % 9;
        end
    endtask

    task automatic place_at(input int t);
        goto_cell(t);
        press(1'b0, 1'b1);
    endtask

    task automatic do_reset;
        bus.btn_move  = 1'b0;
        bus.btn_place = 1'b0;
        rst = 1'b0;
        cycles(2);
        rst = 1'b1;
        cycles(1);
        cur = 0;
    endtask

    task automatic test_reset;
        bus.btn_move  = 1'b0;
        bus.btn_place = 1'b0;
        rst = 1'b0;
        cycles(3);
        tests++;
        if (col !== {9{EM}}) begin fails++; $display("FAIL reset_colors_in_reset: got %h expected %h", col, {9{EM}}); end
        rst = 1'b1;
        cycles(1);
        cur = 0;
        exp_col = {9{EM}};
        exp_col[0] = CU;
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL reset_colors: got %h expected %h", col, exp_col); end
        tests++;
        if (bus.turn !== 1'b0) begin fails++; $display("FAIL reset_turn: got %b expected 0", bus.turn); end
        tests++;
        if (bus.winner !== 2'b00) begin fails++; $display("FAIL reset_winner: got %b expected 00", bus.winner); end
        tests++;
        if (bus.game_over !== 1'b0) begin fails++; $display("FAIL reset_game_over: got %b expected 0", bus.game_over); end
    endtask

    task automatic test_latency_hold;
        do_reset();
        bus.btn_move = 1'b1;
        cycles(4);
        tests++;
        if (col[0] !== CU) begin fails++; $display("FAIL latency_early: got %h expected %h", col[0], CU); end
        cycles(1);
        tests++;
        if (col[1] !== CU) begin fails++; $display("FAIL latency_5cyc: got %h expected %h", col[1], CU); end
        cycles(20);
        bus.btn_move = 1'b0;
        cycles(8);
        cur = 1;
        tests++;
        if (col[1] !== CU || col[2] !== EM) begin
            fails++; $display("FAIL hold_single_event: got A2=%h A3=%h expected A2=%h A3=%h", col[1], col[2], CU, EM);
        end
    endtask

    task automatic test_move_wrap;
        do_reset();
        goto_cell(8);
        press(1'b1, 1'b0);
        cur = 0;
        exp_col = {9{EM}};
        exp_col[0] = CU;
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL wrap_9_moves: got %h expected %h", col, exp_col); end
        press(1'b1, 1'b0);
        cur = 1;
        exp_col[0] = EM;
        exp_col[1] = CU;
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL wrap_10th_move: got %h expected %h", col, exp_col); end
    endtask

    task automatic test_win;
        int changes;
        logic [2:0] prev;
        do_reset();
        place_at(0);
        place_at(3);
        place_at(1);
        place_at(4);
        place_at(2);
        tests++;
        if (bus.winner !== 2'b01) begin fails++; $display("FAIL win_winner: got %b expected 01", bus.winner); end
        tests++;
        if (bus.game_over !== 1'b1) begin fails++; $display("FAIL win_game_over: got %b expected 1", bus.game_over); end
        tests++;
        if (bus.turn !== 1'b0) begin fails++; $display("FAIL win_turn: got %b expected 0", bus.turn); end
        tests++;
        if (col[3] !== P2 || col[4] !== P2 || col[8:5] !== {4{EM}}) begin
            fails++; $display("FAIL win_other_cells: got %h expected B1=B2=%h rest %h", col, P2, EM);
        end
        changes = 0;
        prev = col[0];
        for (int k = 0; k < 17; k++) begin
            tests++;
`ifdef TTT_WIN_BLINK_EN
            if (col[0] !== P1 && col[0] !== EM) begin fails++; $display("FAIL blink_value: got %h expected %h or %h", col[0], P1, EM); end
`else
            if (col[2:0] !== {3{P1}}) begin fails++; $display("FAIL win_static: got %h expected %h", col[2:0], {3{P1}}); end
`endif
            if (col[0] !== prev) changes++;
            prev = col[0];
            cycles(1);
        end
        tests++;
`ifdef TTT_WIN_BLINK_EN
        if (changes != 4) begin fails++; $display("FAIL blink_toggles: got %0d expected 4", changes); end
`else
        if (changes != 0) begin fails++; $display("FAIL static_toggles: got %0d expected 0", changes); end
`endif
        press(1'b1, 1'b0);
        tests++;
        if (bus.winner !== 2'b01 || bus.game_over !== 1'b1) begin
            fails++; $display("FAIL win_move_ignored: got winner=%b over=%b expected 01 1", bus.winner, bus.game_over);
        end
        press(1'b0, 1'b1);
        cur = 0;
        exp_col = {9{EM}};
        exp_col[0] = CU;
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL win_restart_colors: got %h expected %h", col, exp_col); end
        tests++;
        if (bus.winner !== 2'b00 || bus.game_over !== 1'b0 || bus.turn !== 1'b0) begin
            fails++; $display("FAIL win_restart_status: got w=%b o=%b t=%b expected 00 0 0", bus.winner, bus.game_over, bus.turn);
        end
    endtask

    task automatic test_occupied;
        do_reset();
        place_at(0);
        tests++;
        if (bus.turn !== 1'b1) begin fails++; $display("FAIL occ_turn_after_place: got %b expected 1", bus.turn); end
        press(1'b0, 1'b1);
        tests++;
        if (bus.turn !== 1'b1) begin fails++; $display("FAIL occ_turn_unchanged: got %b expected 1", bus.turn); end
        tests++;
        if (col[0] !== P1 || col[8:1] !== {8{EM}}) begin fails++; $display("FAIL occ_board: got %h", col); end
        press(1'b1, 1'b0);
        cur = 1;
        tests++;
        if (col[1] !== CU || bus.game_over !== 1'b0) begin
            fails++; $display("FAIL occ_still_play: got A2=%h over=%b expected %h 0", col[1], bus.game_over, CU);
        end
    endtask

    task automatic test_move_place_same;
        do_reset();
        goto_cell(4);
        press(1'b1, 1'b1);
        tests++;
        if (col[4] !== P1 || bus.turn !== 1'b1) begin
            fails++; $display("FAIL same_claim: got B2=%h turn=%b expected %h 1", col[4], bus.turn, P1);
        end
        tests++;
        if (col[5] !== EM) begin fails++; $display("FAIL same_cursor_stay: got B3=%h expected %h", col[5], EM); end
        press(1'b1, 1'b0);
        cur = 5;
        tests++;
        if (col[5] !== CU) begin fails++; $display("FAIL same_next_move: got B3=%h expected %h", col[5], CU); end
    endtask

    task automatic test_draw;
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        for (int k = 0; k < 9; k++) place_at(seq[k]);
        exp_col = {P1, P1, P2, P2, P2, P1, P1, P2, P1};
        tests++;
        if (bus.winner !== 2'b11 || bus.game_over !== 1'b1) begin
            fails++; $display("FAIL draw_status: got w=%b o=%b expected 11 1", bus.winner, bus.game_over);
        end
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL draw_colors: got %h expected %h", col, exp_col); end
        press(1'b0, 1'b1);
        cur = 0;
        exp_col = {9{EM}};
        exp_col[0] = CU;
        tests++;
        if (col !== exp_col) begin fails++; $display("FAIL draw_restart_colors: got %h expected %h", col, exp_col); end
        tests++;
        if (bus.turn !== 1'b0 || bus.winner !== 2'b00) begin
            fails++; $display("FAIL draw_restart_status: got t=%b w=%b expected 0 00", bus.turn, bus.winner);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        place_at(0);
        press(1'b1, 1'b0);
        #1 rst = 1'b0;
        #1;
        tests++;
        if (col !== {9{EM}} || bus.turn !== 1'b0) begin
            fails++; $display("FAIL async_reset: got %h turn=%b expected %h 0", col, bus.turn, {9{EM}});
        end
        cycles(2);
        rst = 1'b1;
        cycles(1);
        cur = 0;
    endtask

    initial begin
        bus.btn_move  = 1'b0;
        bus.btn_place = 1'b0;
        test_reset();
        test_latency_hold();
        test_move_wrap();
        test_win();
        test_occupied();
        test_move_place_same();
        test_draw();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
